// File: rtl/vsim_msg_src_pkg.sv
package vsim_msg_src_pkg;

  longint src_q [4][$];
  int     calls;
  int     calls_ch [4];

  function automatic longint dpi_msgReceive_beat_ch(input int ch);
    longint r;
    r = 0;
    calls++;
    if (ch >= 0 && ch < 4) begin
      calls_ch[ch]++;
      if (src_q[ch].size() != 0)
        r = src_q[ch].pop_front();
    end
    return r;
  endfunction

endpackage

// File: rtl/vsim_receive_mc.sv
// vsim_receive_mc -- multi-channel simulation receive transactor.
//
// Polls a message source one 32-bit word at a time through the function
// dpi_msgReceive_beat_ch(ch). Channels are polled round-robin. Each
// channel packs WIDTH/32 words into one output beat, or fewer when a word
// carries last=1. Finished beats are buffered in a DEPTH-entry FIFO per channel
// and presented on a valid/ready interface.
//
// Word format: bit 33 = last, bit 32 = valid, bits 31:0 = data word.
//
// Parameters
//   WIDTH    : beat width in bits. Must be a multiple of 32, from 32 to 256.
//   DEPTH    : FIFO entries per channel. Must be a power of 2, from 2 to 64.
//   CHANNELS : number of independent receive channels, from 1 to 4.
//
// Ports
//   CLK        : clock. All state changes on its rising edge.
//   nRST       : synchronous reset, active-high.
//   poll_en    : global enable for polling.
//   out_valid  : one bit per channel. The channel has a beat available.
//   out_ready  : one bit per channel. The consumer accepts the beat.
//   out_data   : beat data. Channel c occupies bits [c*WIDTH +: WIDTH].
//   out_last   : one bit per channel. The beat is the last beat of a message.
//   msg_count  : completed-message count per channel.
//                Channel c occupies bits [c*32 +: 32].
//
// Build option
//   VSIM_RECEIVE_STATS_EN : when this macro is defined, the per-channel message
//   counters are built. When it is undefined, msg_count is tied to 0.
module vsim_receive_mc
  import vsim_msg_src_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     poll_en,
  output logic [CHANNELS-1:0]      out_valid,
  input  logic [CHANNELS-1:0]      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]      out_last,
  output logic [CHANNELS*32-1:0]   msg_count
);

  localparam int WORDS = WIDTH / 32;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Control state. It is cleared by reset.
  logic [PTR_W-1:0] poll_ptr;
  logic [IDX_W-1:0] word_idx [CHANNELS];
  logic [AW-1:0]    rd_ptr   [CHANNELS];
  logic [AW-1:0]    wr_ptr   [CHANNELS];
  logic [AW:0]      count    [CHANNELS];

  // Data storage. It is never reset. The outputs are gated by out_valid, so
  // stale contents are never visible.
  logic [WIDTH-1:0] asm_q     [CHANNELS];
  logic [WIDTH-1:0] fifo_data [CHANNELS][DEPTH];
  logic             fifo_last [CHANNELS][DEPTH];

  logic                room;
  logic                can_poll;
  logic [CHANNELS-1:0] pop;

  // Merges a newly arrived word into the partial beat at word slot idx.
  // Slots below idx keep the earlier words. Slots above idx are forced to
  // zero, so an early last never exposes stale words from an older message.
  function automatic logic [WIDTH-1:0] build_beat(input logic [WIDTH-1:0] partial,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [31:0]      word);
    logic [WIDTH-1:0] beat;
    beat = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (IDX_W'(k) < idx)
        beat[k*32 +: 32] = partial[k*32 +: 32];
      else if (IDX_W'(k) == idx)
        beat[k*32 +: 32] = word;
    end
    return beat;
  endfunction

  // A channel is polled only when its FIFO has room. This check prevents
  // overflow: no call is made whose word could not be stored.
  always_comb begin
    room = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(poll_ptr) == c)
        room = (count[c] < (AW+1)'(DEPTH));
    end
    can_poll = !nRST && poll_en && room;
  end

  assign pop = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    logic [33:0]      rsp;
    logic             take;
    logic             done;
    logic [WIDTH-1:0] beat;

    // This is the only call site, so there is at most one call per cycle.
    rsp = '0;
    if (can_poll)
      rsp = 34'(dpi_msgReceive_beat_ch(int'(poll_ptr)));

    if (nRST) begin
      poll_ptr <= '0;
    end else if (poll_en) begin
      if (poll_ptr == PTR_W'(CHANNELS - 1))
        poll_ptr <= '0;
      else
        poll_ptr <= poll_ptr + 1'b1;
    end

    for (int c = 0; c < CHANNELS; c++) begin
      take = can_poll && (int'(poll_ptr) == c) && rsp[32];
      done = take && (rsp[33] || (word_idx[c] == IDX_W'(WORDS - 1)));
      beat = build_beat(asm_q[c], word_idx[c], rsp[31:0]);

      if (take)
        asm_q[c] <= beat;
      if (done) begin
        fifo_data[c][wr_ptr[c]] <= beat;
        fifo_last[c][wr_ptr[c]] <= rsp[33];
      end

      if (nRST) begin
        word_idx[c] <= '0;
        rd_ptr[c]   <= '0;
        wr_ptr[c]   <= '0;
        count[c]    <= '0;
      end else begin
        if (take)
          word_idx[c] <= done ? '0 : word_idx[c] + 1'b1;
        if (done)
          wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        // A push and a pop in the same cycle cancel out.
        case ({done, pop[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_valid[c] = (count[c] != '0);
      if (out_valid[c]) begin
        out_data[c*WIDTH +: WIDTH] = fifo_data[c][rd_ptr[c]];
        out_last[c]                = fifo_last[c][rd_ptr[c]];
      end
    end
  end

`ifdef VSIM_RECEIVE_STATS_EN
  logic [31:0] msg_cnt [CHANNELS];

  // The counter wraps naturally at 2^32.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (nRST)
        msg_cnt[c] <= '0;
      else if (pop[c] && out_last[c])
        msg_cnt[c] <= msg_cnt[c] + 32'd1;
    end
  end

  always_comb begin
    msg_count = '0;
    for (int c = 0; c < CHANNELS; c++)
      msg_count[c*32 +: 32] = msg_cnt[c];
  end
`else
  assign msg_count = '0;
`endif

endmodule
